// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types and default widths for the data-memory arbiter
//               and the pipeline top that instantiates it.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

   // Default memory geometry, shared with the pipeline top
   localparam int c_ADDR_W = 8;
   localparam int c_DATA_W = 32;

   // Width of the EXT bounded-wait counter (holds MAX_WAIT up to 15)
   localparam int c_WAIT_W = 4;

   // Arbiter priority state
   typedef enum logic [0:0] {
      CPU_PRI   = 1'b0,
      EXT_FORCE = 1'b1
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_wait_counter
// Description : Saturating up-counter with synchronous clear and increment.
//               at_max reports that the value being loaded this cycle equals
//               MAX, so a consumer can react on the same edge the counter
//               reaches its limit.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_wait_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 4
) (
   input  logic clk,
   input  logic rst,      // asynchronous, active-low
   input  logic clear,
   input  logic inc,
   output logic at_max
);

   localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;

   // Next count: clear dominates, increment stops at the limit
   always_comb begin
      w_count_nxt = r_count;
      if (clear) begin
         w_count_nxt = '0;
      end else if (inc && (r_count != c_MAX)) begin
         w_count_nxt = r_count + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign at_max = (w_count_nxt == c_MAX);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the MEM-stage CPU
//               port and an external loader/debug port. The CPU wins by
//               default; after MAX_WAIT consecutive denied EXT cycles the EXT
//               port is forced exactly one slot and the CPU is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = c_ADDR_W,
   parameter int DATA_W   = c_DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,        // asynchronous, active-low
   // CPU (MEM stage) port
   input  logic              cpu_rden,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   // EXT (loader/debug) port
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   // Memory side
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rden,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   arb_state_t r_state;
   logic       r_rd_owner;

   logic w_cpu_acc;
   logic w_ext_sel;
   logic w_wait_clear;
   logic w_wait_inc;
   logic w_wait_at_max;

   assign w_cpu_acc = cpu_rden | cpu_wren;

   // EXT owns the port when the CPU is idle or its wait has run out.
   // Gating with rst keeps every combinational control low during reset.
   assign w_ext_sel = rst & ext_req & (~w_cpu_acc | (r_state == EXT_FORCE));

   assign ext_gnt   = w_ext_sel;
   assign cpu_stall = w_cpu_acc & w_ext_sel;

   // Memory port mux; a CPU store masks a simultaneous CPU load
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rden  = 1'b0;
      mem_wren  = 1'b0;
      if (rst) begin
         if (w_ext_sel) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_wren  = ext_we;
            mem_rden  = ~ext_we;
         end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wren  = cpu_wren;
            mem_rden  = cpu_rden & ~cpu_wren;
         end
      end
   end

   // Consecutive-denial tracking; the counter restarts whenever EXT is
   // served or stops asking.
   assign w_wait_clear = w_ext_sel | ~ext_req;
   assign w_wait_inc   = ext_req & w_cpu_acc & ~w_ext_sel;

   arb_wait_counter #(
      .WIDTH (c_WAIT_W),
      .MAX   (MAX_WAIT)
   ) u_wait_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_wait_clear),
      .inc    (w_wait_inc),
      .at_max (w_wait_at_max)
   );

   // Priority FSM plus read-ownership flag for the one-cycle read return
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= CPU_PRI;
         r_rd_owner <= 1'b0;
      end else begin
         r_rd_owner <= w_ext_sel & ~ext_we;
         case (r_state)
            CPU_PRI: begin
               if (w_wait_at_max) begin
                  r_state <= EXT_FORCE;
               end
            end
            EXT_FORCE: begin
               // One forced slot only; a withdrawn request also releases it
               if (w_ext_sel || !ext_req) begin
                  r_state <= CPU_PRI;
               end
            end
            default: r_state <= CPU_PRI;
         endcase
      end
   end

   // Memory read data fans out to both ports; consumers qualify it
   assign ext_rvalid = r_rd_owner;
   assign ext_rdata  = mem_q;
   assign cpu_rdata  = mem_q;

endmodule
`default_nettype wire
